// File: rtl/uart_io_port_if.sv
// rtl/uart_io_port_if.sv - processor IO bus (port id, OUT data, strobes, IN data)
interface uart_io_port_if;
  logic [7:0] IO_port_ID;
  logic [7:0] IO_write_data;
  logic       IO_write_strobe;
  logic       IO_read_strobe;
  logic [7:0] IO_read_data;

  modport master (
    output IO_port_ID,
    output IO_write_data,
    output IO_write_strobe,
    output IO_read_strobe,
    input  IO_read_data
  );

  modport slave (
    input  IO_port_ID,
    input  IO_write_data,
    input  IO_write_strobe,
    input  IO_read_strobe,
    output IO_read_data
  );
endinterface

// File: rtl/uart_io_port.sv
// rtl/uart_io_port.sv - IO-mapped 8N1 UART with TX/RX FIFOs; define UART_LOOPBACK_EN to feed uart_tx into the receiver
module uart_io_port #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] PORT_DATA    = 8'h01,
  parameter logic [7:0] PORT_RXSTAT  = 8'h02,
  parameter logic [7:0] PORT_TXSTAT  = 8'h03,
  parameter logic [7:0] PORT_ERR     = 8'h04
) (
  input  logic           clk100,
  input  logic           reset_n,
  uart_io_port_if.slave  io,
  input  logic           uart_rx,
  output logic           uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  // ---------------- strobe edge detection ----------------
  logic rd_prev, wr_prev, rd_fire, wr_fire;

  // Remember previous strobe levels so each assertion acts only once
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      rd_prev <= 1'b0;
      wr_prev <= 1'b0;
    end else begin
      rd_prev <= io.IO_read_strobe;
      wr_prev <= io.IO_write_strobe;
    end
  end

  assign rd_fire = io.IO_read_strobe & ~rd_prev;
  assign wr_fire = io.IO_write_strobe & ~wr_prev;

  // ---------------- TX FIFO ----------------
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wptr, tx_rptr;
  logic        tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
  assign tx_push  = wr_fire && (io.IO_port_ID == PORT_DATA) && (!tx_full || tx_pop);

  // TX FIFO pointers; a push into a full FIFO is only taken when the serializer pops that cycle
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk100) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= io.IO_write_data;
  end

  // ---------------- TX serializer ----------------
  tx_state_t     tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]    tx_bit, tx_bit_nx;
  logic [7:0]    tx_shift, tx_shift_nx;
  logic          tx_line_nx;

  // TX state register; uart_tx is registered so the pin never glitches
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
      uart_tx  <= tx_line_nx;
    end
  end

  // TX next state: fetch a byte in IDLE, then start/8 data/stop bits of CLKS_PER_BIT each
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    tx_pop      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop      = 1'b1;
          tx_shift_nx = tx_mem[tx_rptr[AW-1:0]];
          tx_cnt_nx   = '0;
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_state_nx = TX_DATA;
        end else begin
          tx_cnt_nx = tx_cnt + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx = '0;
          if (tx_bit == 3'd7) begin
            tx_state_nx = TX_STOP;
          end else begin
            tx_bit_nx   = tx_bit + 3'd1;
            tx_shift_nx = {1'b0, tx_shift[7:1]};
          end
        end else begin
          tx_cnt_nx = tx_cnt + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx   = '0;
          tx_state_nx = TX_IDLE;
        end else begin
          tx_cnt_nx = tx_cnt + CNT_ONE;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
    case (tx_state_nx)
      TX_START: tx_line_nx = 1'b0;
      TX_DATA:  tx_line_nx = tx_shift_nx[0];
      default:  tx_line_nx = 1'b1;
    endcase
  end

  // ---------------- RX input ----------------
  logic rx_meta, rx_sync, rx_in;

  // Two-flop synchronizer for the asynchronous rx pin
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

`ifdef UART_LOOPBACK_EN
  assign rx_in = uart_tx;
`else
  assign rx_in = rx_sync;
`endif

  // ---------------- RX FIFO ----------------
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wptr, rx_rptr;
  logic        rx_empty, rx_full, rx_push, rx_pop, rx_push_req;

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
  assign rx_pop   = rd_fire && (io.IO_port_ID == PORT_DATA) && !rx_empty;
  assign rx_push  = rx_push_req && (!rx_full || rx_pop);

  // RX FIFO pointers; a CPU pop in the same cycle makes room for a byte arriving at full
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
    end
  end

  // ---------------- RX deserializer ----------------
  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]    rx_bit, rx_bit_nx;
  logic [7:0]    rx_shift, rx_shift_nx;
  logic          frame_set;

  // RX FIFO storage; the completed byte sits in rx_shift during the stop bit
  always_ff @(posedge clk100) begin
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_shift;
  end

  // RX state register
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
    end
  end

  // RX next state: validate start at half bit, then sample each bit at its centre
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_push_req = 1'b0;
    frame_set   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_in) begin
          rx_cnt_nx   = '0;
          rx_state_nx = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nx   = '0;
          rx_bit_nx   = '0;
          rx_state_nx = rx_in ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_nx = rx_cnt + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_in, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
          else                rx_bit_nx   = rx_bit + 3'd1;
        end else begin
          rx_cnt_nx = rx_cnt + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nx = '0;
          if (rx_in) begin
            rx_push_req = 1'b1;
            rx_state_nx = RX_IDLE;
          end else begin
            frame_set   = 1'b1;
            rx_state_nx = RX_WAIT;
          end
        end else begin
          rx_cnt_nx = rx_cnt + CNT_ONE;
        end
      end
      RX_WAIT: begin
        if (rx_in) rx_state_nx = RX_IDLE;
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // ---------------- error flags ----------------
  logic frame_err, rx_overrun, err_rd, overrun_set;

  assign err_rd      = rd_fire && (io.IO_port_ID == PORT_ERR);
  assign overrun_set = rx_push_req && rx_full && !rx_pop;

  // Sticky error flags, cleared by reading PORT_ERR; a new error in the same cycle wins
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (frame_set)   frame_err  <= 1'b1;
      else if (err_rd) frame_err  <= 1'b0;
      if (overrun_set) rx_overrun <= 1'b1;
      else if (err_rd) rx_overrun <= 1'b0;
    end
  end

  // Combinational read-data port decode
  always_comb begin
    io.IO_read_data = 8'hFF;
    if (io.IO_port_ID == PORT_DATA)
      io.IO_read_data = rx_empty ? 8'h00 : rx_mem[rx_rptr[AW-1:0]];
    else if (io.IO_port_ID == PORT_RXSTAT)
      io.IO_read_data = rx_empty ? 8'h00 : 8'hFF;
    else if (io.IO_port_ID == PORT_TXSTAT)
      io.IO_read_data = tx_full ? 8'hFF : 8'h00;
    else if (io.IO_port_ID == PORT_ERR)
      io.IO_read_data = {6'b0, rx_overrun, frame_err};
  end

endmodule

// File: tb/tb_uart_io_port.sv
// tb/tb_uart_io_port.sv - randomized self-checking bench for uart_io_port
module tb_uart_io_port;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk100 = 1'b0;
  logic reset_n = 1'b0;
  logic rx_drv = 1'b1;
  logic loop_mode = 1'b0;
  logic mon_en = 1'b1;
  logic uart_tx;
  logic rx_line;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [7:0] tx_seen [$];
  int         tx_start_t [$];
  logic       tx_stop_ok [$];

  uart_io_port_if bus ();

  assign rx_line = loop_mode ? uart_tx : rx_drv;

  uart_io_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk100  (clk100),
    .reset_n (reset_n),
    .io      (bus.slave),
    .uart_rx (rx_line),
    .uart_tx (uart_tx)
  );

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;

  // Line monitor: decodes uart_tx frames at bit centres
  initial begin
    forever begin
      @(negedge clk100);
      if (mon_en && reset_n && uart_tx === 1'b0) begin
        int t0;
        logic [7:0] b;
        logic ok;
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk100);
        ok = (uart_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk100);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk100);
        ok = ok && (uart_tx === 1'b1);
        if (mon_en) begin
          tx_seen.push_back(b);
          tx_start_t.push_back(t0);
          tx_stop_ok.push_back(ok);
        end
      end
    end
  end

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    @(negedge clk100);
    bus.IO_port_ID      = port;
    bus.IO_write_data   = data;
    bus.IO_write_strobe = 1'b1;
    @(negedge clk100);
    bus.IO_write_strobe = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] data);
    @(negedge clk100);
    bus.IO_port_ID     = port;
    bus.IO_read_strobe = 1'b1;
    #1 data = bus.IO_read_data;
    @(negedge clk100);
    bus.IO_read_strobe = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk100);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk100);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk100);
    end
    rx_drv = stop;
    repeat (CPB) @(negedge clk100);
    rx_drv = 1'b1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k;
    k = 0;
    while (tx_seen.size() < n && k < budget) begin
      @(negedge clk100);
      k++;
    end
    total++;
    if (tx_seen.size() < n) begin
      bad++;
      $display("FAIL wait_tx frames=%0d need=%0d (timeout)", tx_seen.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic [7:0] p;
    bus.IO_port_ID      = 8'h00;
    bus.IO_write_data   = 8'h00;
    bus.IO_write_strobe = 1'b0;
    bus.IO_read_strobe  = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk100);
    total++;
    if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", uart_tx); end
    reset_n = 1'b1;
    io_read(8'h01, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", d); end
    io_read(8'h02, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL reset_rxstat got=%h want=00", d); end
    io_read(8'h03, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL reset_txstat got=%h want=00", d); end
    io_read(8'h04, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL reset_err got=%h want=00", d); end
    p = 8'($urandom_range(5, 255));
    io_read(p, d);
    total++;
    if (d !== 8'hFF) begin bad++; $display("FAIL unmapped port=%h got=%h want=FF", p, d); end
  endtask

  task automatic test_tx_frame();
    logic [7:0] b;
    logic [9:0] frame;
    logic ok;
    int lat;
    b = 8'hA5;
    frame = {1'b1, b, 1'b0};
    tx_seen.delete(); tx_start_t.delete(); tx_stop_ok.delete();
    io_write(8'h01, b);
    lat = 0;
    while (uart_tx !== 1'b0 && lat < 8) begin
      @(negedge clk100);
      lat++;
    end
    total++;
    if (uart_tx !== 1'b0) begin bad++; $display("FAIL tx_start_latency got=%0d want<8", lat); end
    for (int i = 0; i < 10; i++) begin
      ok = 1'b1;
      repeat (CPB) begin
        if (uart_tx !== frame[i]) ok = 1'b0;
        @(negedge clk100);
      end
      total++;
      if (!ok) begin bad++; $display("FAIL tx_bit%0d not held at %b for %0d cycles", i, frame[i], CPB); end
    end
    ok = 1'b1;
    repeat (3 * CPB) begin
      if (uart_tx !== 1'b1) ok = 1'b0;
      @(negedge clk100);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL tx_idle_after got=low want=high"); end
  endtask

  task automatic test_tx_full();
    logic [7:0] exp_q [$];
    logic [7:0] d;
    logic [7:0] prior;
    int occ;
    tx_seen.delete(); tx_start_t.delete(); tx_stop_ok.delete();
    prior = 8'($urandom);
    io_write(8'h01, prior);
    exp_q.push_back(prior);
    repeat (4) @(negedge clk100);
    occ = 0;
    for (int k = 0; k < 5; k++) begin
      d = 8'(8'h11 * (k + 1));
      io_write(8'h01, d);
      if (occ < DEPTH) begin
        occ++;
        exp_q.push_back(d);
      end
      io_read(8'h03, d);
      total++;
      if (d !== ((occ == DEPTH) ? 8'hFF : 8'h00)) begin
        bad++; $display("FAIL txstat after write %0d got=%h want=%h", k + 1, d, (occ == DEPTH) ? 8'hFF : 8'h00);
      end
    end
    wait_tx(exp_q.size(), (exp_q.size() + 1) * 11 * CPB);
    repeat (2 * CPB) @(negedge clk100);
    total++;
    if (tx_seen.size() != exp_q.size()) begin
      bad++; $display("FAIL tx_full count got=%0d want=%0d", tx_seen.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < tx_seen.size(); i++) begin
      total++;
      if (tx_seen[i] !== exp_q[i]) begin bad++; $display("FAIL tx_full byte%0d got=%h want=%h", i, tx_seen[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [$];
    logic [7:0] b;
    int gap;
    tx_seen.delete(); tx_start_t.delete(); tx_stop_ok.delete();
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      io_write(8'h01, b);
    end
    wait_tx(3, 4 * 11 * CPB);
    for (int i = 0; i < 3 && i < tx_seen.size(); i++) begin
      total++;
      if (tx_seen[i] !== exp_q[i] || tx_stop_ok[i] !== 1'b1) begin
        bad++; $display("FAIL b2b byte%0d got=%h stop=%b want=%h stop=1", i, tx_seen[i], tx_stop_ok[i], exp_q[i]);
      end
    end
    for (int i = 1; i < tx_start_t.size(); i++) begin
      gap = tx_start_t[i] - tx_start_t[i-1];
      total++;
      if (gap < 10 * CPB || gap > 10 * CPB + 1) begin
        bad++; $display("FAIL b2b gap%0d got=%0d want=%0d..%0d", i, gap, 10 * CPB, 10 * CPB + 1);
      end
    end
  endtask

  task automatic test_rx_basic();
    logic [7:0] d;
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'h3C : 8'($urandom);
      send_frame(b, 1'b1);
      repeat (4) @(negedge clk100);
      io_read(8'h02, d);
      total++;
      if (d !== 8'hFF) begin bad++; $display("FAIL rx_stat_full frame%0d got=%h want=FF", k, d); end
      io_read(8'h01, d);
      total++;
      if (d !== b) begin bad++; $display("FAIL rx_data frame%0d got=%h want=%h", k, d, b); end
      io_read(8'h02, d);
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL rx_stat_empty frame%0d got=%h want=00", k, d); end
    end
    io_read(8'h01, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL rx_pop_empty got=%h want=00", d); end
  endtask

  task automatic test_rx_frame_err();
    logic [7:0] d;
    send_frame(8'($urandom), 1'b0);
    repeat (4) @(negedge clk100);
    io_read(8'h04, d);
    total++;
    if (d !== 8'h01) begin bad++; $display("FAIL frame_err got=%h want=01", d); end
    io_read(8'h02, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL frame_err_discard got=%h want=00", d); end
    io_read(8'h04, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL frame_err_clear got=%h want=00", d); end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] model_q [$];
    logic [7:0] d;
    logic [7:0] b;
    logic ovr;
    ovr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else ovr = 1'b1;
    end
    repeat (4) @(negedge clk100);
    io_read(8'h04, d);
    total++;
    if (d !== {6'b0, ovr, 1'b0}) begin bad++; $display("FAIL overrun_flag got=%h want=%h", d, {6'b0, ovr, 1'b0}); end
    while (model_q.size() > 0) begin
      b = model_q.pop_front();
      io_read(8'h01, d);
      total++;
      if (d !== b) begin bad++; $display("FAIL overrun_data got=%h want=%h", d, b); end
    end
    io_read(8'h02, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL overrun_drained got=%h want=00", d); end
    @(negedge clk100);
    rx_drv = 1'b0;
    @(negedge clk100);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk100);
    io_read(8'h02, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL glitch_rxstat got=%h want=00", d); end
    io_read(8'h04, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL glitch_err got=%h want=00", d); end
  endtask

  task automatic test_loopback();
    logic [7:0] d;
    logic [7:0] b;
    logic ok;
    int lat;
    loop_mode = 1'b1;
    b = 8'($urandom);
    io_write(8'h01, b);
    repeat (12 * CPB) @(negedge clk100);
    io_read(8'h02, d);
    total++;
    if (d !== 8'hFF) begin bad++; $display("FAIL loop_rxstat got=%h want=FF", d); end
    io_read(8'h01, d);
    total++;
    if (d !== b) begin bad++; $display("FAIL loop_data got=%h want=%h", d, b); end
    io_write(8'h01, 8'($urandom));
    lat = 0;
    while (uart_tx !== 1'b0 && lat < 8) begin
      @(negedge clk100);
      lat++;
    end
    repeat (3 * CPB) @(negedge clk100);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    total++;
    if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_midframe_tx got=%b want=1", uart_tx); end
    repeat (2) @(negedge clk100);
    reset_n = 1'b1;
    io_read(8'h02, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL reset_midframe_rxstat got=%h want=00", d); end
    ok = 1'b1;
    repeat (12 * CPB) begin
      if (uart_tx !== 1'b1) ok = 1'b0;
      @(negedge clk100);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL reset_midframe_txfifo uart_tx went low after reset"); end
    io_read(8'h02, d);
    total++;
    if (d !== 8'h00) begin bad++; $display("FAIL reset_midframe_rx_partial got=%h want=00", d); end
    loop_mode = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_tx_full();
    test_back_to_back();
    test_rx_basic();
    test_rx_frame_err();
    test_rx_overrun();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk100);
    bad++;
    $display("FAIL watchdog cycles=%0d limit=60000", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
